// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
// Holds the FSM state encoding, the table-width helper and the settle counter width.
package tt_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int unsigned SETTLE_CNT_W = 4;

  // Number of truth-table entries for an n-input function.
  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tt_sweep_checker.sv
// Drives every input combination onto a pair of function blocks, captures both truth
// tables and reports per-minterm differences, the first differing index and equivalence.
module tt_sweep_checker
  import tt_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [N_IN-1:0]           vec,
  input  logic                      s_full,
  input  logic                      s_simp,
  output logic                      busy,
  output logic                      done,
  output logic [tt_width(N_IN)-1:0] tt_full,
  output logic [tt_width(N_IN)-1:0] tt_simp,
  output logic [tt_width(N_IN)-1:0] mismatch,
  output logic                      equal,
  output logic [N_IN-1:0]           first_bad,
  output logic                      first_bad_valid
);

  localparam int unsigned TT_W = tt_width(N_IN);
  localparam logic [N_IN-1:0] VEC_LAST = N_IN'(TT_W - 1);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST =
    SETTLE_CNT_W'((SETTLE > 0) ? (SETTLE - 1) : 0);
  // With no settle window the FSM goes straight from one sample to the next.
  localparam state_t STEP_STATE = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;

  state_t                  state;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic                    diff;
  logic [TT_W-1:0]         mis_next;

  // Mismatch vector including the sample being taken this cycle, so equal sees it.
  always_comb begin
    diff     = s_full ^ s_simp;
    mis_next = mismatch;
    mis_next[vec] = diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      settle_cnt      <= '0;
      vec             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      tt_full         <= '0;
      tt_simp         <= '0;
      mismatch        <= '0;
      equal           <= 1'b0;
      first_bad       <= '0;
      first_bad_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          vec  <= '0;
          busy <= 1'b0;
          if (start) begin
            tt_full         <= '0;
            tt_simp         <= '0;
            mismatch        <= '0;
            equal           <= 1'b0;
            first_bad       <= '0;
            first_bad_valid <= 1'b0;
            settle_cnt      <= '0;
            busy            <= 1'b1;
            state           <= STEP_STATE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_CNT_W'(1);
          end
        end

        S_SAMPLE: begin
          tt_full[vec] <= s_full;
          tt_simp[vec] <= s_simp;
          mismatch     <= mis_next;
          if (diff && !first_bad_valid) begin
            first_bad       <= vec;
            first_bad_valid <= 1'b1;
          end
          if (vec == VEC_LAST) begin
            vec   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            equal <= ~|mis_next;
            state <= S_DONE;
          end else begin
            vec   <= vec + N_IN'(1);
            state <= STEP_STATE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: one instance with the default settle window and
// one with SETTLE=3, both fed by selectable reference function pairs.
module tb_tt_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [2:0] vec_a, vec_b;
  logic       sf_a, ss_a, sf_b, ss_b;
  logic       busy_a, done_a, equal_a, fbv_a;
  logic       busy_b, done_b, equal_b, fbv_b;
  logic [7:0] ttf_a, tts_a, mis_a, ttf_b, tts_b, mis_b;
  logic [2:0] fb_a, fb_b;
  int         mode;
  int         errors = 0;
  int         checks = 0;
  int         cyc;

  always #5 clk = ~clk;

  tt_sweep_checker #(.N_IN(3), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vec(vec_a),
    .s_full(sf_a), .s_simp(ss_a), .busy(busy_a), .done(done_a),
    .tt_full(ttf_a), .tt_simp(tts_a), .mismatch(mis_a), .equal(equal_a),
    .first_bad(fb_a), .first_bad_valid(fbv_a)
  );

  tt_sweep_checker #(.N_IN(3), .SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vec(vec_b),
    .s_full(sf_b), .s_simp(ss_b), .busy(busy_b), .done(done_b),
    .tt_full(ttf_b), .tt_simp(tts_b), .mismatch(mis_b), .equal(equal_b),
    .first_bad(fb_b), .first_bad_valid(fbv_b)
  );

  // Function pairs under test: {s_full, s_simp} for input {x,y,z}.
  function automatic logic [1:0] fpair(input int m, input logic [2:0] v);
    logic x, y, z, f, s;
    x = v[2]; y = v[1]; z = v[0];
    case (m)
      0: begin
        f = (x|y|z) & (x|~y|~z) & (~x|~y|~z) & (~x|y|z);
        s = (y|z) & (~y|~z);
      end
      1: begin
        f = (x|y|~z) & (~x|~y|~z) & (~x|y|~z);
        s = (y|~z) & (~x|z);
      end
      2: begin f = 1'b1; s = 1'b0; end
      default: begin f = 1'b1; s = 1'b1; end
    endcase
    return {f, s};
  endfunction

  always_comb {sf_a, ss_a} = fpair(mode, vec_a);
  always_comb {sf_b, ss_b} = fpair(mode, vec_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a sweep on instance A; optionally pulse start again at cycle poke. Returns the
  // cycle (1 = first cycle after accept) in which done was seen, or 99 on timeout.
  task automatic run_a(input int poke, output int done_cyc);
    int n;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 1;
    chk("accept_busy", 32'(busy_a), 32'd1);
    chk("accept_vec", 32'(vec_a), 32'd0);
    done_cyc = 99;
    while (n < 60) begin
      start_a = (n == poke);
      @(posedge clk); #1;
      n++;
      if (done_a) begin
        done_cyc = n;
        break;
      end
    end
    start_a = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    mode    = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec", 32'(vec_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_tt_full", 32'(ttf_a), 32'd0);
    chk("rst_tt_simp", 32'(tts_a), 32'd0);
    chk("rst_mismatch", 32'(mis_a), 32'd0);
    chk("rst_equal", 32'(equal_a), 32'd0);
    chk("rst_first_bad", 32'(fb_a), 32'd0);
    chk("rst_fbv", 32'(fbv_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Equivalent pair
    mode = 0;
    run_a(0, cyc);
    chk("eq_done_cycle", 32'(cyc), 32'd17);
    chk("eq_busy_in_done", 32'(busy_a), 32'd0);
    chk("eq_tt_full", 32'(ttf_a), 32'h66);
    chk("eq_tt_simp", 32'(tts_a), 32'h66);
    chk("eq_mismatch", 32'(mis_a), 32'h00);
    chk("eq_equal", 32'(equal_a), 32'd1);
    chk("eq_fbv", 32'(fbv_a), 32'd0);
    chk("eq_vec_done", 32'(vec_a), 32'd0);
    @(posedge clk); #1;
    chk("eq_done_pulse", 32'(done_a), 32'd0);

    // Non-equivalent pair with a start poke at cycle 5 that must be ignored
    mode = 1;
    run_a(5, cyc);
    chk("ne_done_cycle", 32'(cyc), 32'd17);
    chk("ne_tt_full", 32'(ttf_a), 32'h5D);
    chk("ne_tt_simp", 32'(tts_a), 32'h8D);
    chk("ne_mismatch", 32'(mis_a), 32'hD0);
    chk("ne_equal", 32'(equal_a), 32'd0);
    chk("ne_first_bad", 32'(fb_a), 32'd4);
    chk("ne_fbv", 32'(fbv_a), 32'd1);
    @(posedge clk); #1;
    chk("ne_idle_busy", 32'(busy_a), 32'd0);

    // Start during DONE is ignored, then accepted one cycle later
    mode = 0;
    run_a(0, cyc);
    chk("dn_done_cycle", 32'(cyc), 32'd17);
    start_a = 1'b1;
    @(posedge clk); #1;
    chk("dn_ignored_busy", 32'(busy_a), 32'd0);
    chk("dn_ignored_tt", 32'(ttf_a), 32'h66);
    chk("dn_ignored_equal", 32'(equal_a), 32'd1);
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("dn_accept_busy", 32'(busy_a), 32'd1);
    chk("dn_accept_tt", 32'(ttf_a), 32'h00);
    chk("dn_accept_equal", 32'(equal_a), 32'd0);
    cyc = 99;
    for (int n = 2; n < 60; n++) begin
      @(posedge clk); #1;
      if (done_a) begin
        cyc = n;
        break;
      end
    end
    chk("dn_rerun_cycle", 32'(cyc), 32'd17);
    chk("dn_rerun_equal", 32'(equal_a), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset mid-sweep at vec=3
    mode = 1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (vec_a == 3'd3) break;
      @(posedge clk); #1;
    end
    chk("mr_reached_vec3", 32'(vec_a), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_vec", 32'(vec_a), 32'd0);
    chk("mr_busy", 32'(busy_a), 32'd0);
    chk("mr_tt_full", 32'(ttf_a), 32'd0);
    chk("mr_mismatch", 32'(mis_a), 32'd0);
    chk("mr_fbv", 32'(fbv_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mr_stays_idle", 32'(busy_a), 32'd0);
    chk("mr_idle_vec", 32'(vec_a), 32'd0);
    run_a(0, cyc);
    chk("mr_done_cycle", 32'(cyc), 32'd17);
    chk("mr_mismatch_after", 32'(mis_a), 32'hD0);
    chk("mr_first_bad", 32'(fb_a), 32'd4);
    @(posedge clk); #1;

    // Constant functions
    mode = 2;
    run_a(0, cyc);
    chk("c10_done_cycle", 32'(cyc), 32'd17);
    chk("c10_tt_full", 32'(ttf_a), 32'hFF);
    chk("c10_tt_simp", 32'(tts_a), 32'h00);
    chk("c10_mismatch", 32'(mis_a), 32'hFF);
    chk("c10_first_bad", 32'(fb_a), 32'd0);
    chk("c10_fbv", 32'(fbv_a), 32'd1);
    chk("c10_equal", 32'(equal_a), 32'd0);
    @(posedge clk); #1;
    mode = 3;
    run_a(0, cyc);
    chk("c11_tt_full", 32'(ttf_a), 32'hFF);
    chk("c11_tt_simp", 32'(tts_a), 32'hFF);
    chk("c11_mismatch", 32'(mis_a), 32'h00);
    chk("c11_equal", 32'(equal_a), 32'd1);
    chk("c11_fbv", 32'(fbv_a), 32'd0);
    @(posedge clk); #1;

    // SETTLE=3 timing on instance B: each vec held 4 cycles, busy 32, done at 33
    mode = 0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      chk($sformatf("s3_vec_c%0d", n), 32'(vec_b), 32'((n - 1) / 4));
      chk($sformatf("s3_busy_c%0d", n), 32'(busy_b), 32'd1);
      chk($sformatf("s3_nodone_c%0d", n), 32'(done_b), 32'd0);
      @(posedge clk); #1;
    end
    chk("s3_done_c33", 32'(done_b), 32'd1);
    chk("s3_busy_c33", 32'(busy_b), 32'd0);
    chk("s3_tt_full", 32'(ttf_b), 32'h66);
    chk("s3_equal", 32'(equal_b), 32'd1);
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      chk($sformatf("s3_hold_done_%0d", n), 32'(done_b), 32'd0);
      chk($sformatf("s3_hold_tt_%0d", n), 32'({ttf_b, tts_b, mis_b}), 32'h666600);
      chk($sformatf("s3_hold_equal_%0d", n), 32'(equal_b), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
